// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide unit.
// Holds XLEN, the decoder's 5-bit op codes, the FSM state encoding and small helpers.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // Op codes as produced by the ALU operation decoder
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01010;
  localparam logic [4:0] OP_MULHSU = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // All eight M-extension codes share the 01xxx prefix
  function automatic logic is_valid_op(input logic [4:0] op);
    return op[4:3] == 2'b01;
  endfunction

  // DIV/DIVU/REM/REMU share the 011xx prefix
  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b011;
  endfunction

  // Two's-complement negate when neg is set
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shared iterative datapath for unsigned shift-add multiply and
// restoring divide on operand magnitudes, plus the XLEN-step iteration counter.
// The accumulator holds {product_hi, product_lo} or {remainder, quotient}.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            div_mode,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic            last,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  count;
  logic              running;
  logic              div_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_wide;
  logic [XLEN:0]     diff;

  // One iteration step: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_wide = acc[2*XLEN-1:XLEN-1];
    diff     = rem_wide - {1'b0, opnd};
    acc_next = {mul_sum, acc[XLEN-1:1]};
    if (div_q) begin
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_wide[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end
  end

  assign last   = running && (count == CNT_W'(XLEN-1));
  assign nxt_hi = acc_next[2*XLEN-1:XLEN];
  assign nxt_lo = acc_next[XLEN-1:0];

  // Load operands on start, then step the accumulator once per cycle for XLEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      running <= 1'b0;
      div_q   <= 1'b0;
    end else if (start) begin
      acc     <= {{XLEN{1'b0}}, mag_a};
      opnd    <= mag_b;
      count   <= '0;
      running <= 1'b1;
      div_q   <= div_mode;
    end else if (running) begin
      acc <= acc_next;
      if (last) begin
        count   <= '0;
        running <= 1'b0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide with valid/ready on both sides.
// Owns the IDLE/CALC/DONE FSM, sign/magnitude handling and short-path results.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  state_t            state, state_next;
  logic [4:0]        op_q;
  logic              neg_lo_q, neg_hi_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              short_hit;
  logic [XLEN-1:0]   short_res;
  logic              core_start, core_last;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   calc_res;

  assign a_neg = a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
  assign b_neg = b[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
  assign mag_a = neg_if(a_neg, a);
  assign mag_b = neg_if(b_neg, b);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [2*XLEN-1:0] fast_fix;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_fix  = (a_neg ^ b_neg) ? (~fast_prod + 1'b1) : fast_prod;
`endif

  // Cases resolved without iterating: bad op, divide by zero, signed overflow, and fast multiply
  always_comb begin
    short_hit = 1'b0;
    short_res = '0;
    if (!is_valid_op(op)) begin
      short_hit = 1'b1;
    end else if (is_div_op(op) && (b == '0)) begin
      short_hit = 1'b1;
      short_res = op[1] ? a : '1;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1)) begin
      short_hit = 1'b1;
      short_res = op[1] ? '0 : a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div_op(op)) begin
      short_hit = 1'b1;
      short_res = (op == OP_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .div_mode (is_div_op(op)),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .last     (core_last),
    .nxt_hi   (nxt_hi),
    .nxt_lo   (nxt_lo)
  );

  // Sign-correct the final accumulator value and pick the half the op asks for
  always_comb begin
    prod_fix = neg_lo_q ? (~{nxt_hi, nxt_lo} + 1'b1) : {nxt_hi, nxt_lo};
    case (op_q)
      OP_MUL:                        calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:  calc_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = neg_if(neg_lo_q, nxt_lo);
      OP_REM, OP_REMU:               calc_res = neg_if(neg_hi_q, nxt_hi);
      default:                       calc_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (short_hit) begin
            state_next = DONE;
          end else begin
            state_next = CALC;
            core_start = 1'b1;
          end
        end
      end
      CALC: begin
        if (core_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture op and sign flags at acceptance; result only moves on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result   <= '0;
    end else if ((state == IDLE) && in_valid) begin
      op_q     <= op;
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
      if (short_hit) result <= short_res;
    end else if ((state == CALC) && core_last) begin
      result <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (table vectors, random ops
// against a 64-bit arithmetic model, backpressure and reset-abort sequences).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference model straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [4:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
    longint sa, sb, ua, ub, p;
    sa = {{32{f_a[31]}}, f_a};
    sb = {{32{f_b[31]}}, f_b};
    ua = {32'b0, f_a};
    ub = {32'b0, f_b};
    case (f_op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (f_b == 32'd0) return 32'hFFFF_FFFF;
        if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return f_a;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (f_b == 32'd0) return f_a;
        if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (f_b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REMU: begin
        if (f_b == 32'd0) return f_a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Expected cycles from acceptance to out_valid
  function automatic int ref_latency(input logic [4:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
    if (f_op < 5'b01000 || f_op > 5'b01111) return 1;
    if (f_op < 5'b01100) return MUL_LAT;
    if (f_b == 32'd0) return 1;
    if ((f_op == OP_DIV || f_op == OP_REM) && f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one op at a negedge, accept it, then count cycles until out_valid
  task automatic applyStimulus(input logic [4:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                               output int lat, output logic [31:0] res);
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: out_valid never rose within %0d cycles", lat);
    end
    res = result;
  endtask

  // With out_ready high the op completes at the next edge; in_ready must follow
  task automatic completeOp(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " in_ready after completion"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [4:0]  ops[8];
    int          lat;
    logic [31:0] res, ra, rb;
    logic [4:0]  rop;

    ops = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    vecs.push_back('{OP_MUL,    32'd7,          32'd6,          32'h0000_002A, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, MUL_LAT});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, MUL_LAT});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{OP_DIVU,   32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, DIV_LAT});
    vecs.push_back('{OP_REMU,   32'hFFFF_FFF9,  32'd2,          32'h0000_0001, DIV_LAT});
    vecs.push_back('{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, 1});
    vecs.push_back('{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1});
    vecs.push_back('{OP_REM,    32'd5,          32'd0,          32'h0000_0005, 1});
    vecs.push_back('{OP_REMU,   32'd5,          32'd0,          32'h0000_0005, 1});
    vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1});
    vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1});
    vecs.push_back('{5'b10000,  32'd3,          32'd4,          32'h0000_0000, 1});
    vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, MUL_LAT});

    // Reset state
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      checkOutput($sformatf("vec%0d op=%b result", i, vecs[i].op), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      completeOp($sformatf("vec%0d", i));
    end

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      rop = (($urandom_range(0, 9)) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 4))
        0: begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 20); end
        1: begin ra = $urandom; rb = 32'd0; end
        2: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      applyStimulus(rop, ra, rb, lat, res);
      checkOutput($sformatf("rand%0d op=%b a=%h b=%h result", n, rop, ra, rb), res, ref_model(rop, ra, rb));
      checkOutput($sformatf("rand%0d latency", n), 32'(lat), 32'(ref_latency(rop, ra, rb)));
      completeOp($sformatf("rand%0d", n));
    end

    // Backpressure: hold the result in DONE while a new request is offered
    out_ready = 1'b0;
    applyStimulus(OP_MUL, 32'd7, 32'd6, lat, res);
    checkOutput("bp result", res, 32'h2A);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
      @(negedge clk);
      checkOutput($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d result", i), result, 32'h2A);
      checkOutput($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp in_ready after release", 32'(in_ready), 32'd1);
    checkOutput("bp out_valid after release", 32'(out_valid), 32'd0);

    // Reset in the middle of CALC discards the partial result
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checkOutput("abort busy in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort result", result, 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, lat, res);
    checkOutput("post-abort DIVU result", res, 32'd14);
    checkOutput("post-abort DIVU latency", 32'(lat), 32'(DIV_LAT));
    completeOp("post-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
